vsync_frame_controller: RTL and testbench
=========================================

VSYNC_FRAME_CONTROLLER -- requirements
Module: vsync_frame_controller

Interface
REQ-001 SHALL have parameter W, default 10, width of all timing, length and position fields.
REQ-002 SHALL have port clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port Enable  input  1  level; permits starting or continuing frames.
REQ-005 SHALL have port LineEnd  input  1  one-clock pulse from the hsync module marking end of one line.
REQ-006 SHALL have ports VSynchPulse, VBackPorch, VActiveLines, VFrontPorch  input  W each  vertical phase lengths in lines.
REQ-007 SHALL have ports HSynchPulseIn, HBackPorchIn, HActiveVideoIn, HFrontPorchIn  input  W each  requested horizontal timing.
REQ-008 SHALL have ports SynchPulse, BackPorch, ActiveVideo, FrontPorch  output  W each  horizontal timing driven to the hsync module.
REQ-009 SHALL have port vsync  output  1  vertical sync, high during the SYNC phase.
REQ-010 SHALL have port yposition  output  W  active line index.
REQ-011 SHALL have port VideoOn  output  1  high during the ACTIVE phase.
REQ-012 SHALL have port FrameEnd  output  1  one-clock pulse at frame completion.

Function
REQ-013 SHALL implement states IDLE, SYNC, BACK, ACTIVE, FRONT.
REQ-014 In IDLE with Enable=1, SHALL latch all eight length inputs into shadow registers, then enter the first phase with nonzero shadow length, in the order SYNC, BACK, ACTIVE, FRONT, on the next clock.
REQ-015 SHALL remain in IDLE, without latching, when all four vertical lengths are 0.
REQ-016 SHALL drive SynchPulse/BackPorch/ActiveVideo/FrontPorch from the horizontal shadow registers only; input changes mid-frame SHALL NOT affect outputs before the next latch.
REQ-017 SHALL ignore vertical input changes mid-frame.
REQ-018 In each phase, SHALL increment a W-bit line counter on LineEnd.
REQ-019 On the LineEnd where counter equals shadow length minus 1, SHALL clear the counter and advance to the next nonzero-length phase, skipping zero-length phases.
REQ-020 SHALL ignore LineEnd in IDLE, including a LineEnd coincident with the IDLE-exit latch.
REQ-021 Advancing out of FRONT (or out of the last nonzero phase) with Enable=1, SHALL re-latch all inputs on that same edge and begin the next frame.
REQ-022 Advancing out of FRONT (or out of the last nonzero phase) with Enable=0, SHALL enter IDLE.
REQ-023 Deasserting Enable mid-frame SHALL NOT truncate the frame.
REQ-024 FrameEnd SHALL pulse for exactly one clock, on the clock after the frame-completing LineEnd edge.
REQ-025 vsync SHALL be registered and high exactly while state is SYNC.
REQ-026 VideoOn SHALL be registered and high exactly while state is ACTIVE.
REQ-027 yposition SHALL equal the line counter during ACTIVE and 0 otherwise.
REQ-028 yposition SHALL reach VActiveLines-1 and never exceed it.
REQ-029 Latency SHALL be exactly one clock from the qualifying LineEnd to any output change.

Reset
REQ-030 On reset=1, SHALL force state IDLE, counter 0, all shadow registers 0, vsync 0, VideoOn 0, FrameEnd 0, yposition 0, and all four horizontal timing outputs 0, immediately and independent of clock.
REQ-031 After reset deasserts, SHALL require a full IDLE-exit latch before any output other than zeros.
REQ-032 Reset mid-frame SHALL abandon the frame with no FrameEnd pulse.

Structure
REQ-033 Shared package SHALL hold the state enumeration, the phase order, and the default W=10.
REQ-034 SHALL contain one sub-module, line_phase_counter (W-bit counter with LineEnd increment, terminal compare against a length, and synchronous clear).
REQ-035 All remaining logic SHALL be in the top module.

Verification
REQ-036 Lengths 2/3/5/2, Enable=1, LineEnd every 8 clocks -> vsync high for 2 lines, VideoOn for 5 lines with yposition 0..4, and FrameEnd one clock after the 12th LineEnd.
REQ-037 VBackPorch=0, others 2/–/5/2 -> SYNC goes directly to ACTIVE; FrameEnd after the 9th LineEnd.
REQ-038 HActiveVideoIn changed 5->8 during ACTIVE -> ActiveVideo stays 5 until the next frame latch, then becomes 8.
REQ-039 Enable dropped during BACK -> frame completes, FrameEnd pulses, state IDLE, and vsync stays 0 afterwards.
REQ-040 reset asserted mid-ACTIVE at yposition=3 -> all outputs 0 without waiting for a clock edge, and no FrameEnd.
REQ-041 All vertical lengths 0 with Enable=1 -> remains IDLE with outputs 0; LineEnd pulses ignored.

Source files
------------

// File: rtl/vsync_frame_controller_pkg.sv
// Shared definitions for the vertical frame controller: state encoding,
// phase order and default field width.
package vsync_frame_controller_pkg;

    localparam int DEFAULT_W = 10;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SYNC   = 3'd1;
    localparam logic [2:0] ST_BACK   = 3'd2;
    localparam logic [2:0] ST_ACTIVE = 3'd3;
    localparam logic [2:0] ST_FRONT  = 3'd4;

    localparam logic [2:0] PHASE_ORDER [4] = '{ST_SYNC, ST_BACK, ST_ACTIVE, ST_FRONT};

    // First phase after cur (in frame order) whose length is nonzero; IDLE if none remain.
    // nz[i] flags the phase at PHASE_ORDER[i].
    function automatic logic [2:0] next_phase(input logic [2:0] cur, input logic [3:0] nz);
        logic [2:0] res;
        res = ST_IDLE;
        for (int i = 3; i >= 0; i--) begin
            if (nz[i[1:0]] && (PHASE_ORDER[i[1:0]] > cur))
                res = PHASE_ORDER[i[1:0]];
        end
        return res;
    endfunction

endpackage

// File: rtl/vsync_frame_controller_line_phase_counter.sv
// Line counter for the current vertical phase, with terminal compare against
// the phase length.
module line_phase_counter
    import vsync_frame_controller_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    input  logic [W-1:0] len,
    output logic [W-1:0] count,
    output logic         last
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc)
            count <= count + 1'b1;
    end

    assign last = (count == len - 1'b1);

endmodule

// File: rtl/vsync_frame_controller.sv
// Vertical timing sequencer: walks SYNC/BACK/ACTIVE/FRONT by counting line
// ends and hands latched horizontal timing to the hsync block.
module vsync_frame_controller
    import vsync_frame_controller_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         Enable,
    input  logic         LineEnd,
    input  logic [W-1:0] VSynchPulse,
    input  logic [W-1:0] VBackPorch,
    input  logic [W-1:0] VActiveLines,
    input  logic [W-1:0] VFrontPorch,
    input  logic [W-1:0] HSynchPulseIn,
    input  logic [W-1:0] HBackPorchIn,
    input  logic [W-1:0] HActiveVideoIn,
    input  logic [W-1:0] HFrontPorchIn,
    output logic [W-1:0] SynchPulse,
    output logic [W-1:0] BackPorch,
    output logic [W-1:0] ActiveVideo,
    output logic [W-1:0] FrontPorch,
    output logic         vsync,
    output logic [W-1:0] yposition,
    output logic         VideoOn,
    output logic         FrameEnd
);

    logic [2:0]   state, state_nxt;
    logic [W-1:0] sh_sync, sh_back, sh_active, sh_front;
    logic [W-1:0] cur_len, count;
    logic [3:0]   sh_nz, in_nz;
    logic         last, line_tick, adv, frame_done, do_latch;

    assign in_nz = {VFrontPorch != '0, VActiveLines != '0, VBackPorch != '0, VSynchPulse != '0};
    assign sh_nz = {sh_front != '0, sh_active != '0, sh_back != '0, sh_sync != '0};

    assign line_tick  = LineEnd && (state != ST_IDLE);
    assign adv        = line_tick && last;
    assign frame_done = adv && (next_phase(state, sh_nz) == ST_IDLE);
    // A new frame latches either from IDLE or back-to-back on the frame-completing line.
    assign do_latch   = Enable && (|in_nz) && ((state == ST_IDLE) || frame_done);

    always_comb begin
        cur_len = '0;
        case (state)
            ST_SYNC:   cur_len = sh_sync;
            ST_BACK:   cur_len = sh_back;
            ST_ACTIVE: cur_len = sh_active;
            ST_FRONT:  cur_len = sh_front;
            default:   cur_len = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        if (do_latch)
            state_nxt = next_phase(ST_IDLE, in_nz);
        else if (frame_done)
            state_nxt = ST_IDLE;
        else if (adv)
            state_nxt = next_phase(state, sh_nz);
    end

    line_phase_counter #(.W(W)) u_line_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (line_tick),
        .clr   (adv),
        .len   (cur_len),
        .count (count),
        .last  (last)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            vsync       <= 1'b0;
            VideoOn     <= 1'b0;
            FrameEnd    <= 1'b0;
            sh_sync     <= '0;
            sh_back     <= '0;
            sh_active   <= '0;
            sh_front    <= '0;
            SynchPulse  <= '0;
            BackPorch   <= '0;
            ActiveVideo <= '0;
            FrontPorch  <= '0;
        end else begin
            state    <= state_nxt;
            vsync    <= (state_nxt == ST_SYNC);
            VideoOn  <= (state_nxt == ST_ACTIVE);
            FrameEnd <= frame_done;
            if (do_latch) begin
                sh_sync     <= VSynchPulse;
                sh_back     <= VBackPorch;
                sh_active   <= VActiveLines;
                sh_front    <= VFrontPorch;
                SynchPulse  <= HSynchPulseIn;
                BackPorch   <= HBackPorchIn;
                ActiveVideo <= HActiveVideoIn;
                FrontPorch  <= HFrontPorchIn;
            end
        end
    end

    // VideoOn is the registered ACTIVE decode, so this only exposes the counter during ACTIVE.
    assign yposition = VideoOn ? count : '0;

endmodule

// File: tb/tb_vsync_frame_controller.sv
// Self-checking bench for vsync_frame_controller: directed scenarios plus a
// randomized run against a line-number based frame model.
module tb_vsync_frame_controller;

    localparam int W = 10;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         Enable = 1'b0;
    logic         LineEnd = 1'b0;
    logic [W-1:0] VSynchPulse = '0, VBackPorch = '0, VActiveLines = '0, VFrontPorch = '0;
    logic [W-1:0] HSynchPulseIn = '0, HBackPorchIn = '0, HActiveVideoIn = '0, HFrontPorchIn = '0;
    logic [W-1:0] SynchPulse, BackPorch, ActiveVideo, FrontPorch, yposition;
    logic         vsync, VideoOn, FrameEnd;

    vsync_frame_controller #(.W(W)) dut (
        .clock          (clock),
        .reset          (reset),
        .Enable         (Enable),
        .LineEnd        (LineEnd),
        .VSynchPulse    (VSynchPulse),
        .VBackPorch     (VBackPorch),
        .VActiveLines   (VActiveLines),
        .VFrontPorch    (VFrontPorch),
        .HSynchPulseIn  (HSynchPulseIn),
        .HBackPorchIn   (HBackPorchIn),
        .HActiveVideoIn (HActiveVideoIn),
        .HFrontPorchIn  (HFrontPorchIn),
        .SynchPulse     (SynchPulse),
        .BackPorch      (BackPorch),
        .ActiveVideo    (ActiveVideo),
        .FrontPorch     (FrontPorch),
        .vsync          (vsync),
        .yposition      (yposition),
        .VideoOn        (VideoOn),
        .FrameEnd       (FrameEnd)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame model: a frame is a run of lines numbered 0..total-1; the phase
    // and active index follow from where the line number falls.
    bit m_act = 1'b0;
    int ln = 0;
    int lv [4] = '{0, 0, 0, 0};
    int lh [4] = '{0, 0, 0, 0};
    bit e_vs = 1'b0, e_von = 1'b0, e_fe = 1'b0;
    int e_yp = 0;

    function automatic int vin_sum();
        return int'(VSynchPulse) + int'(VBackPorch) + int'(VActiveLines) + int'(VFrontPorch);
    endfunction

    task automatic model_latch();
        lv[0] = int'(VSynchPulse);   lv[1] = int'(VBackPorch);
        lv[2] = int'(VActiveLines);  lv[3] = int'(VFrontPorch);
        lh[0] = int'(HSynchPulseIn); lh[1] = int'(HBackPorchIn);
        lh[2] = int'(HActiveVideoIn); lh[3] = int'(HFrontPorchIn);
        ln = 0;
        m_act = 1'b1;
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_act = 1'b0;
            ln = 0;
            e_fe = 1'b0;
            for (int i = 0; i < 4; i++) begin
                lv[i] = 0;
                lh[i] = 0;
            end
        end else begin
            e_fe = 1'b0;
            if (!m_act) begin
                if (Enable && vin_sum() > 0) model_latch();
            end else if (LineEnd) begin
                ln++;
                if (ln == lv[0] + lv[1] + lv[2] + lv[3]) begin
                    e_fe = 1'b1;
                    if (Enable && vin_sum() > 0) model_latch();
                    else begin
                        m_act = 1'b0;
                        ln = 0;
                    end
                end
            end
        end
        e_vs  = m_act && (ln < lv[0]);
        e_von = m_act && (ln >= lv[0] + lv[1]) && (ln < lv[0] + lv[1] + lv[2]);
        e_yp  = e_von ? ln - lv[0] - lv[1] : 0;
    end

    always @(negedge clock) begin
        check("vsync", int'(vsync), int'(e_vs));
        check("VideoOn", int'(VideoOn), int'(e_von));
        check("FrameEnd", int'(FrameEnd), int'(e_fe));
        check("yposition", int'(yposition), e_yp);
        check("SynchPulse", int'(SynchPulse), lh[0]);
        check("BackPorch", int'(BackPorch), lh[1]);
        check("ActiveVideo", int'(ActiveVideo), lh[2]);
        check("FrontPorch", int'(FrontPorch), lh[3]);
    end

    // Event tallies for the directed scenarios.
    int le_cnt = 0, vs_lines = 0, von_lines = 0, ysum = 0;
    int fe_cnt = 0, fe_at = 0;

    always @(posedge clock) begin
        if (LineEnd && !reset) begin
            le_cnt++;
            if (vsync) vs_lines++;
            if (VideoOn) begin
                von_lines++;
                ysum += int'(yposition);
            end
        end
    end

    always @(negedge clock) begin
        if (FrameEnd) begin
            fe_cnt++;
            fe_at = le_cnt;
        end
    end

    task automatic step(input bit le);
        LineEnd = le;
        @(posedge clock);
        #2;
        LineEnd = 1'b0;
    endtask

    task automatic line8();
        repeat (7) step(1'b0);
        step(1'b1);
    endtask

    task automatic set_v(input int s, input int b, input int a, input int f);
        VSynchPulse = W'(s); VBackPorch = W'(b); VActiveLines = W'(a); VFrontPorch = W'(f);
    endtask

    int le_b, fe_b, vs_b, von_b, ys_b;

    task automatic snap();
        le_b = le_cnt; fe_b = fe_cnt; vs_b = vs_lines; von_b = von_lines; ys_b = ysum;
    endtask

    initial begin
        #1;
        check("reset_vsync", int'(vsync), 0);
        check("reset_ActiveVideo", int'(ActiveVideo), 0);
        @(posedge clock);
        #2;
        reset = 1'b0;
        step(1'b0);

        // All vertical lengths zero: stays idle, nothing latched.
        HSynchPulseIn = 10'd7; HBackPorchIn = 10'd7; HActiveVideoIn = 10'd7; HFrontPorchIn = 10'd7;
        set_v(0, 0, 0, 0);
        Enable = 1'b1;
        snap();
        repeat (3) line8();
        check("zero_len_frameend", fe_cnt - fe_b, 0);
        check("zero_len_vsync_lines", vs_lines - vs_b, 0);
        check("zero_len_SynchPulse", int'(SynchPulse), 0);

        // 2/3/5/2 frame with horizontal change mid-ACTIVE.
        HSynchPulseIn = 10'd1; HBackPorchIn = 10'd2; HActiveVideoIn = 10'd5; HFrontPorchIn = 10'd4;
        set_v(2, 3, 5, 2);
        step(1'b0);
        snap();
        repeat (7) line8();
        HActiveVideoIn = 10'd8;
        step(1'b0);
        check("hold_ActiveVideo", int'(ActiveVideo), 5);
        repeat (5) line8();
        step(1'b0);
        check("basic_frameend_count", fe_cnt - fe_b, 1);
        check("basic_frameend_line", fe_at - le_b, 12);
        check("basic_vsync_lines", vs_lines - vs_b, 2);
        check("basic_videoon_lines", von_lines - von_b, 5);
        check("basic_ypos_sum", ysum - ys_b, 10);
        check("relatch_ActiveVideo", int'(ActiveVideo), 8);

        // Enable dropped during BACK of the follow-on frame.
        snap();
        repeat (3) line8();
        Enable = 1'b0;
        repeat (9) line8();
        step(1'b0);
        check("drop_frameend_count", fe_cnt - fe_b, 1);
        snap();
        repeat (3) line8();
        check("drop_vsync_lines", vs_lines - vs_b, 0);
        check("drop_vsync", int'(vsync), 0);

        // No back porch: SYNC goes straight to ACTIVE.
        set_v(2, 0, 5, 2);
        Enable = 1'b1;
        step(1'b0);
        Enable = 1'b0;
        snap();
        repeat (2) line8();
        check("noback_videoon", int'(VideoOn), 1);
        repeat (7) line8();
        step(1'b0);
        check("noback_frameend_line", fe_at - le_b, 9);
        check("noback_frameend_count", fe_cnt - fe_b, 1);
        check("noback_videoon_lines", von_lines - von_b, 5);

        // Reset mid-ACTIVE at yposition 3.
        set_v(2, 3, 5, 2);
        Enable = 1'b1;
        step(1'b0);
        repeat (8) line8();
        check("pre_reset_ypos", int'(yposition), 3);
        snap();
        @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_ypos", int'(yposition), 0);
        check("async_reset_VideoOn", int'(VideoOn), 0);
        check("async_reset_ActiveVideo", int'(ActiveVideo), 0);
        check("async_reset_FrameEnd", int'(FrameEnd), 0);
        @(posedge clock);
        #2;
        repeat (3) step(1'b1);
        check("reset_no_frameend", fe_cnt - fe_b, 0);
        reset = 1'b0;

        // Randomized run.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0)
                set_v($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
            if ($urandom_range(0, 29) == 0) begin
                HSynchPulseIn  = W'($urandom_range(0, 1023));
                HBackPorchIn   = W'($urandom_range(0, 1023));
                HActiveVideoIn = W'($urandom_range(0, 1023));
                HFrontPorchIn  = W'($urandom_range(0, 1023));
            end
            if ($urandom_range(0, 49) == 0) Enable = ~Enable;
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 599) == 0) reset = 1'b1;
            step($urandom_range(0, 2) == 0);
        end

        Enable = 1'b0;
        reset = 1'b0;
        repeat (4) step(1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
